// File: rtl/floor_request_encoder.sv
// Turns per-floor call buttons into single-floor FIFO write strobes: edge detect,
// duplicate suppression, round-robin arbitration, write throttling and service release.
module floor_request_encoder #(
    parameter int pFLOOR_WIDTH = 4,
    parameter int pNUM_FLOORS  = 16
) (
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    input  logic [pNUM_FLOORS-1:0]  i_buttons,
    input  logic                    i_fifo_full,
    input  logic                    i_open_door,
    input  logic [pFLOOR_WIDTH-1:0] i_current_floor,
    output logic                    o_wr_en,
    output logic [pFLOOR_WIDTH-1:0] o_floor_no,
    output logic [pNUM_FLOORS-1:0]  o_pending
);

    localparam int FW = pFLOOR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t                  state_r;
    logic [pNUM_FLOORS-1:0]  pend_r;
    logic [pNUM_FLOORS-1:0]  queued_r;
    logic [pNUM_FLOORS-1:0]  btn_prev_r;
    logic [FW-1:0]           rr_ptr_r;

    logic [pNUM_FLOORS-1:0]  press_s;
    logic [pNUM_FLOORS-1:0]  clr_mask_s;
    logic [pNUM_FLOORS-1:0]  new_set_s;
    logic [pNUM_FLOORS-1:0]  grant_mask_s;
    logic [pNUM_FLOORS-1:0]  pend_next_s;
    logic [pNUM_FLOORS-1:0]  queued_next_s;
    logic [FW-1:0]           idx_hi_s;
    logic [FW-1:0]           idx_any_s;
    logic                    found_hi_s;
    logic                    found_any_s;
    logic [FW-1:0]           grant_idx_s;
    logic                    grant_fire_s;
    logic [FW-1:0]           rr_next_s;

    // Round-robin pick: lowest pending floor at or above rr_ptr, else lowest pending overall.
    always_comb begin
        idx_hi_s    = {FW{1'b0}};
        idx_any_s   = {FW{1'b0}};
        found_hi_s  = 1'b0;
        found_any_s = 1'b0;
        for (int k = pNUM_FLOORS - 1; k >= 0; k--) begin
            idx_hi_s    = (pend_r[k] && (FW'(k) >= rr_ptr_r)) ? FW'(k) : idx_hi_s;
            found_hi_s  = found_hi_s | (pend_r[k] && (FW'(k) >= rr_ptr_r));
            idx_any_s   = pend_r[k] ? FW'(k) : idx_any_s;
            found_any_s = found_any_s | pend_r[k];
        end
        grant_idx_s  = found_hi_s ? idx_hi_s : idx_any_s;
        grant_fire_s = (state_r == ST_IDLE) && !i_fifo_full && found_any_s;
        rr_next_s    = (grant_idx_s == FW'(pNUM_FLOORS - 1)) ? {FW{1'b0}} : (grant_idx_s + {{(FW-1){1'b0}}, 1'b1});
    end

    // Per-floor next state; an out-of-range current floor matches no k and so clears nothing.
    always_comb begin
        press_s = i_buttons & ~btn_prev_r;
        for (int k = 0; k < pNUM_FLOORS; k++) begin
            clr_mask_s[k]   = i_open_door && (i_current_floor == FW'(k));
            grant_mask_s[k] = grant_fire_s && (grant_idx_s == FW'(k));
        end
        new_set_s     = press_s & ~pend_r & ~queued_r & ~clr_mask_s;
        pend_next_s   = (pend_r | new_set_s) & ~clr_mask_s & ~grant_mask_s;
        queued_next_s = (queued_r | grant_mask_s) & ~clr_mask_s;
    end

    // Write FSM, per-floor state and registered outputs.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r    <= ST_IDLE;
            pend_r     <= {pNUM_FLOORS{1'b0}};
            queued_r   <= {pNUM_FLOORS{1'b0}};
            btn_prev_r <= {pNUM_FLOORS{1'b0}};
            rr_ptr_r   <= {FW{1'b0}};
            o_wr_en    <= 1'b0;
            o_floor_no <= {FW{1'b0}};
            o_pending  <= {pNUM_FLOORS{1'b0}};
        end else begin
            btn_prev_r <= i_buttons;
            pend_r     <= pend_next_s;
            queued_r   <= queued_next_s;
            o_pending  <= pend_next_s | queued_next_s;
            case (state_r)
                ST_IDLE: begin
                    if (grant_fire_s) begin
                        o_wr_en    <= 1'b1;
                        o_floor_no <= grant_idx_s;
                        rr_ptr_r   <= rr_next_s;
                        state_r    <= ST_WRITE;
                    end else begin
                        o_wr_en    <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    o_wr_en <= 1'b0;
                    state_r <= ST_GAP;
                end
                // Dead cycle so the full flag reflects the write just made.
                ST_GAP: begin
                    o_wr_en <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    o_wr_en <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_floor_request_encoder.sv
// Directed and randomized checks of floor_request_encoder against a cycle-level
// behavioural model of the request lifecycle.
module tb_floor_request_encoder;

    localparam int NUM = 16;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic [15:0] i_buttons;
    logic        i_fifo_full;
    logic        i_open_door;
    logic [3:0]  i_current_floor;
    logic        o_wr_en;
    logic [3:0]  o_floor_no;
    logic [15:0] o_pending;

    int checks = 0;
    int errors = 0;

    // model state
    bit [15:0] m_pend, m_queued, m_prev;
    int        m_rr, m_busy, m_floor;
    bit        m_wr;

    floor_request_encoder #(.pFLOOR_WIDTH(4), .pNUM_FLOORS(16)) dut (
        .i_clock(clk), .i_reset_n(i_reset_n), .i_buttons(i_buttons),
        .i_fifo_full(i_fifo_full), .i_open_door(i_open_door),
        .i_current_floor(i_current_floor), .o_wr_en(o_wr_en),
        .o_floor_no(o_floor_no), .o_pending(o_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_queued = '0; m_prev = '0;
        m_rr = 0; m_busy = 0; m_floor = 0; m_wr = 1'b0;
    endtask

    // One rising edge of the reference behaviour.
    task automatic model_step(input bit [15:0] btn, input bit full, input bit door, input int cur);
        int        grant;
        bit [15:0] clr;
        grant = -1;
        if (m_busy == 0 && m_pend != 16'h0 && !full) begin
            for (int i = 0; i < NUM; i++) begin
                if (grant < 0 && m_pend[(m_rr + i) % NUM]) grant = (m_rr + i) % NUM;
            end
        end
        clr = '0;
        if (door && cur < NUM) clr[cur] = 1'b1;
        for (int k = 0; k < NUM; k++) begin
            if (btn[k] && !m_prev[k] && !m_pend[k] && !m_queued[k]) m_pend[k] = 1'b1;
        end
        if (grant >= 0) begin
            m_pend[grant]   = 1'b0;
            m_queued[grant] = 1'b1;
        end
        m_pend   = m_pend & ~clr;
        m_queued = m_queued & ~clr;
        m_prev   = btn;
        if (grant >= 0) begin
            m_wr = 1'b1; m_floor = grant; m_rr = (grant + 1) % NUM; m_busy = 2;
        end else begin
            m_wr = 1'b0;
            if (m_busy > 0) m_busy--;
        end
    endtask

    // Drive at the falling edge, step the model, then sample at the next falling edge.
    task automatic cyc(input bit [15:0] btn, input bit full = 1'b0, input bit door = 1'b0, input int cur = 0);
        i_buttons = btn; i_fifo_full = full; i_open_door = door; i_current_floor = 4'(cur);
        model_step(btn, full, door, cur);
        @(posedge clk);
        @(negedge clk);
        chk("wr_en", 32'(o_wr_en), 32'(m_wr));
        chk("floor_no", 32'(o_floor_no), 32'(m_floor));
        chk("pending", 32'(o_pending), 32'(m_pend | m_queued));
    endtask

    task automatic do_reset(input bit [15:0] held);
        i_reset_n = 1'b0; i_buttons = held; i_fifo_full = 1'b0; i_open_door = 1'b0; i_current_floor = 4'd0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_wr_en", 32'(o_wr_en), 32'd0);
        chk("rst_floor", 32'(o_floor_no), 32'd0);
        chk("rst_pending", 32'(o_pending), 32'd0);
        i_reset_n = 1'b1;
    endtask

    bit [15:0] rb;

    initial begin
        do_reset(16'h0);

        // single press: write two cycles later, one pulse
        cyc(16'h0020);
        chk("t1_nowr_yet", 32'(o_wr_en), 32'd0);
        chk("t1_lamp", 32'(o_pending), 32'h0020);
        cyc(16'h0020);
        chk("t1_wr", 32'(o_wr_en), 32'd1);
        chk("t1_floor", 32'(o_floor_no), 32'd5);
        cyc(16'h0020);
        chk("t1_pulse", 32'(o_wr_en), 32'd0);

        // re-press before service: no duplicate
        cyc(16'h0000);
        for (int i = 0; i < 4; i++) begin
            cyc(16'h0020);
            chk("t2_nowr", 32'(o_wr_en), 32'd0);
            chk("t2_lamp", 32'(o_pending), 32'h0020);
        end

        // three simultaneous presses from rr_ptr=0, then a wrapped pair
        do_reset(16'h0);
        cyc(16'h4204);
        cyc(16'h4204);
        chk("t3_first", 32'(o_floor_no), 32'd2);
        chk("t3_first_wr", 32'(o_wr_en), 32'd1);
        repeat (3) cyc(16'h4204);
        chk("t3_second", 32'(o_floor_no), 32'd9);
        chk("t3_second_wr", 32'(o_wr_en), 32'd1);
        repeat (3) cyc(16'h4204);
        chk("t3_third", 32'(o_floor_no), 32'd14);
        chk("t3_third_wr", 32'(o_wr_en), 32'd1);
        cyc(16'h0000);
        cyc(16'h0000);
        // rr_ptr is now 15: the search wraps through 0 and 1 before reaching 3
        cyc(16'h000A);
        cyc(16'h000A);
        chk("t3_wrap_a", 32'(o_floor_no), 32'd1);
        repeat (3) cyc(16'h000A);
        chk("t3_wrap_b", 32'(o_floor_no), 32'd3);
        chk("t3_wrap_b_wr", 32'(o_wr_en), 32'd1);
        cyc(16'h0000);
        cyc(16'h0000);

        // FIFO full holds the request; dropping full releases it
        for (int i = 0; i < 4; i++) begin
            cyc(16'h0080, 1'b1);
            chk("t4_nowr", 32'(o_wr_en), 32'd0);
            chk("t4_lamp7", 32'(o_pending[7]), 32'd1);
        end
        cyc(16'h0080, 1'b0);
        chk("t4_wr", 32'(o_wr_en), 32'd1);
        chk("t4_floor", 32'(o_floor_no), 32'd7);

        // service clear of queued floor 4 beats a simultaneous press
        cyc(16'h0000);
        cyc(16'h0000);
        cyc(16'h0010);
        cyc(16'h0010);
        chk("t5_write4", 32'(o_floor_no), 32'd4);
        cyc(16'h0000);
        cyc(16'h0000);
        chk("t5_queued4", 32'(o_pending[4]), 32'd1);
        cyc(16'h0010, 1'b0, 1'b1, 4);
        chk("t5_clear", 32'(o_pending[4]), 32'd0);
        cyc(16'h0010);
        chk("t5_ignored", 32'(o_pending[4]), 32'd0);
        chk("t5_ignored_wr", 32'(o_wr_en), 32'd0);

        // asynchronous reset while a write strobe is high
        do_reset(16'h0);
        cyc(16'h0100);
        cyc(16'h0100);
        chk("t6_in_write", 32'(o_wr_en), 32'd1);
        i_reset_n = 1'b0;
        i_buttons = 16'h0040;
        #1;
        chk("t6_async_wr", 32'(o_wr_en), 32'd0);
        chk("t6_async_pend", 32'(o_pending), 32'd0);
        model_reset();
        @(negedge clk);
        i_reset_n = 1'b1;
        // button held through reset counts as a fresh press
        cyc(16'h0040);
        chk("t6_held_press", 32'(o_pending), 32'h0040);

        // randomized traffic against the model
        rb = 16'h0040;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 2) == 0) rb[$urandom_range(0, 15)] ^= 1'b1;
            cyc(rb, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), int'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
